tstdp_scheduler: RTL and testbench

TSTDP_SCHEDULER -- requirements
Module: tstdp_scheduler

---
 rtl/tstdp_scheduler.sv | 149 ++++++++++++++
 tb/tb_tstdp_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tstdp_scheduler.sv
// tstdp_scheduler: update-tick generator, spike edge capture and DECAY/PRE/POST command issue.
// Optional PAIR opcode (both flags served at once) is enabled by defining TSTDP_SCHED_PAIR_EN.
`default_nettype none

module tstdp_scheduler #(
  parameter int unsigned CLK_DIV = 6250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pre_spike,
  input  logic       post_spike,
  output logic       upd_valid,
  input  logic       upd_ready,
  output logic [1:0] upd_op,
  output logic       tick,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int unsigned   CW        = 28;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [1:0]    C_OP_DECAY = 2'b00;
  localparam logic [1:0]    C_OP_PRE   = 2'b01;
  localparam logic [1:0]    C_OP_POST  = 2'b10;
  localparam logic [1:0]    C_OP_PAIR  = 2'b11;
`ifdef TSTDP_SCHED_PAIR_EN
  localparam bit C_PAIR_EN = 1'b1;
`else
  localparam bit C_PAIR_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pre_q, r_post_q;
  logic          r_pre_pend, r_post_pend;
  logic          r_valid, r_busy;
  logic [1:0]    r_op;
  logic [7:0]    r_drop;

  logic       w_tick, w_issue, w_stall;
  logic       w_pre_edge, w_post_edge;
  logic       w_clr_pre, w_clr_post;
  logic       w_pre_drop, w_post_drop;
  logic [1:0] w_op;
  logic [1:0] w_ndrop;
  logic [8:0] w_drop_sum;

  assign w_tick      = enable && (r_cnt == C_CNT_MAX);
  assign w_issue     = w_tick && (r_state == S_IDLE);
  assign w_stall     = w_tick && (r_state == S_ISSUE);
  assign w_pre_edge  = pre_spike & ~r_pre_q;
  assign w_post_edge = post_spike & ~r_post_q;

  // Opcode is chosen from the flags as they stand before this cycle's edges land.
  always_comb begin
    w_op       = C_OP_DECAY;
    w_clr_pre  = 1'b0;
    w_clr_post = 1'b0;
    if (w_issue) begin
      if (C_PAIR_EN && r_pre_pend && r_post_pend) begin
        w_op       = C_OP_PAIR;
        w_clr_pre  = 1'b1;
        w_clr_post = 1'b1;
      end else if (r_pre_pend) begin
        w_op      = C_OP_PRE;
        w_clr_pre = 1'b1;
      end else if (r_post_pend) begin
        w_op       = C_OP_POST;
        w_clr_post = 1'b1;
      end
    end
  end

  assign w_pre_drop  = enable && w_pre_edge && r_pre_pend && !w_clr_pre;
  assign w_post_drop = enable && w_post_edge && r_post_pend && !w_clr_post;
  assign w_ndrop     = {1'b0, w_pre_drop} + {1'b0, w_post_drop} + {1'b0, w_stall};
  assign w_drop_sum  = {1'b0, r_drop} + {7'd0, w_ndrop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_pre_q     <= 1'b0;
      r_post_q    <= 1'b0;
      r_pre_pend  <= 1'b0;
      r_post_pend <= 1'b0;
      r_drop      <= 8'd0;
    end else begin
      r_pre_q  <= pre_spike;
      r_post_q <= post_spike;
      if (!enable || (r_cnt == C_CNT_MAX)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (!enable) begin
        r_pre_pend  <= 1'b0;
        r_post_pend <= 1'b0;
      end else begin
        r_pre_pend  <= (r_pre_pend & ~w_clr_pre) | w_pre_edge;
        r_post_pend <= (r_post_pend & ~w_clr_post) | w_post_edge;
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_op    <= C_OP_DECAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_op    <= w_op;
          end
        end
        S_ISSUE: begin
          if (r_valid && upd_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign upd_valid = r_valid;
  assign upd_op    = r_op;
  assign busy      = r_busy;
  assign tick      = w_tick;
  assign drop_cnt  = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_tstdp_scheduler.sv
// tb_tstdp_scheduler: per-cycle vector table with a command scoreboard, plus a drop-counter saturation sequence.
`default_nettype none

module tb_tstdp_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic       upd_ready = 1'b1;
  logic       upd_valid;
  logic [1:0] upd_op;
  logic       tick;
  logic [7:0] drop_cnt;
  logic       busy;

  always #5 clk = ~clk;

  tstdp_scheduler #(.CLK_DIV(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_op     (upd_op),
    .tick       (tick),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  // Ops seen when both flags are pending: first tick, then following tick.
`ifdef TSTDP_SCHED_PAIR_EN
  localparam logic [1:0] C_B1 = 2'b11;
  localparam logic [1:0] C_B2 = 2'b00;
`else
  localparam logic [1:0] C_B1 = 2'b01;
  localparam logic [1:0] C_B2 = 2'b10;
`endif

  typedef struct {
    logic       r, e, pr, po, rd;
    logic       t, v;
    logic [1:0] op;
    logic       b;
    logic [7:0] d;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] sb[$];
  int         errors = 0;
  int         checks = 0;
  string      cur = "";
  int         n_tick = 0;
  int         n_valid = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void row(input logic r, input logic e, input logic pr, input logic po,
                              input logic rd, input logic t, input logic v, input logic [1:0] op,
                              input logic b, input logic [7:0] d);
    vec_t x;
    x.r = r; x.e = e; x.pr = pr; x.po = po; x.rd = rd;
    x.t = t; x.v = v; x.op = op; x.b = b; x.d = d; x.name = cur;
    vecs.push_back(x);
  endfunction

  function automatic void rst_row();
    row(0, 1, 0, 0, 1, 0, 0, 2'b00, 0, 8'd0);
  endfunction
  function automatic void idle(input logic [7:0] d);
    row(1, 1, 0, 0, 1, 0, 0, 2'b00, 0, d);
  endfunction
  function automatic void tk(input logic [7:0] d);
    row(1, 1, 0, 0, 1, 1, 0, 2'b00, 0, d);
  endfunction
  function automatic void vo(input logic [1:0] op, input logic [7:0] d);
    row(1, 1, 0, 0, 1, 0, 1, op, 1, d);
  endfunction
  function automatic void head(input logic [7:0] d);
    idle(d); idle(d); idle(d); tk(d);
  endfunction
  function automatic void q(input logic [1:0] op, input logic [7:0] d);
    vo(op, d); idle(d); idle(d); tk(d);
  endfunction

  // Scoreboard: every accepted command must match the oldest expected opcode.
  always @(negedge clk) begin
    logic [1:0] e_op;
    if (reset && upd_valid && upd_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got op %0b expected no command", upd_op);
      end else begin
        e_op = sb.pop_front();
        check("sb_op", {30'd0, upd_op}, {30'd0, e_op});
      end
    end
  end

  task automatic run_table();
    vec_t       x;
    logic [1:0] a_op, e_op;
    for (int i = 0; i < vecs.size(); i++) begin
      x = vecs[i];
      reset = x.r; enable = x.e; pre_spike = x.pr; post_spike = x.po; upd_ready = x.rd;
      if (x.r && x.v && x.rd) sb.push_back(x.op);
      @(negedge clk);
      a_op = (x.v || !x.r) ? upd_op : 2'b00;
      e_op = (x.v || !x.r) ? x.op : 2'b00;
      check($sformatf("%s row%0d {tick,valid,op,busy,drop}", x.name, i),
            {19'd0, tick, upd_valid, a_op, busy, drop_cnt},
            {19'd0, x.t, x.v, e_op, x.b, x.d});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stepw();
    @(negedge clk);
    if (tick) n_tick++;
    if (upd_valid) n_valid++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    cur = "quiet";
    rst_row(); head(0); q(2'b00, 0); q(2'b00, 0); vo(2'b00, 0);

    cur = "pre";
    rst_row(); idle(0);
    row(1, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 0, 1, 1, 0, 2'b00, 0, 0);
    q(2'b01, 0); vo(2'b00, 0);

    cur = "both";
    rst_row(); idle(0);
    row(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 1, 1, 1, 0, 2'b00, 0, 0);
    q(C_B1, 0); q(C_B2, 0); vo(2'b00, 0);

    cur = "edge_on_clear";
    rst_row(); idle(0);
    row(1, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 0, 1, 1, 0, 2'b00, 0, 0);
    q(2'b01, 0); q(2'b01, 0); vo(2'b00, 0);

    cur = "edge_in_tick";
    rst_row(); idle(0); idle(0); idle(0);
    row(1, 1, 0, 1, 1, 1, 0, 2'b00, 0, 0);
    q(2'b00, 0); vo(2'b10, 0);

    cur = "double_drop";
    rst_row();
    row(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 1, 1, 1, 0, 2'b00, 0, 2);
    q(C_B1, 2); q(C_B2, 2); vo(2'b00, 2);

    cur = "stall";
    rst_row(); head(0);
    row(1, 1, 0, 0, 0, 0, 1, 2'b00, 1, 0);
    row(1, 1, 0, 0, 0, 0, 1, 2'b00, 1, 0);
    row(1, 1, 0, 0, 0, 0, 1, 2'b00, 1, 0);
    row(1, 1, 0, 0, 0, 1, 1, 2'b00, 1, 0);
    row(1, 1, 0, 0, 0, 0, 1, 2'b00, 1, 1);
    row(1, 1, 0, 0, 0, 0, 1, 2'b00, 1, 1);
    row(1, 1, 0, 0, 1, 0, 1, 2'b00, 1, 1);
    row(1, 1, 0, 0, 1, 1, 0, 2'b00, 0, 1);
    vo(2'b00, 1);

    cur = "reset_mid_issue";
    rst_row();
    row(1, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 0, 1, 1, 0, 2'b00, 0, 1);
    row(1, 1, 0, 0, 0, 0, 1, 2'b01, 1, 1);
    row(1, 1, 0, 0, 0, 0, 1, 2'b01, 1, 1);
    row(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    head(0); vo(2'b00, 0);

    cur = "enable_low";
    rst_row(); idle(0);
    row(1, 1, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 1, 1, 0, 0, 2'b00, 0, 0);
    row(1, 1, 1, 1, 1, 1, 0, 2'b00, 0, 0);
    row(1, 0, 0, 0, 0, 0, 1, C_B1, 1, 0);
    row(1, 0, 0, 0, 1, 0, 1, C_B1, 1, 0);
    row(1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    row(1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    head(0); vo(2'b00, 0);

    run_table();

    // Saturation: flags repeatedly set then dropped, enable pulsed low so no tick ever fires.
    reset = 1'b0; enable = 1'b0; pre_spike = 1'b0; post_spike = 1'b0; upd_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < 301; w++) begin
      enable = 1'b1; post_spike = 1'b1; stepw();
      post_spike = 1'b0; stepw();
      post_spike = 1'b1; stepw();
      enable = 1'b0; post_spike = 1'b0; stepw();
      if (w == 9) check("sat drop after 10 windows", {24'd0, drop_cnt}, 32'd10);
      if (w == 254) check("sat drop reaches 255", {24'd0, drop_cnt}, 32'd255);
    end
    check("sat drop held at 255", {24'd0, drop_cnt}, 32'd255);
    check("sat no tick", n_tick, 0);
    check("sat no command", n_valid, 0);

    sb.push_back(2'b00);
    enable = 1'b1;
    k = 0;
    while (!upd_valid && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    check("sat next command valid", {31'd0, upd_valid}, 32'd1);
    @(negedge clk); #1;
    @(posedge clk); #1;
    check("sat drop after command", {24'd0, drop_cnt}, 32'd255);
    check("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
